uart_rx: RTL
============

# uart_rx

Serial UART receiver for the UART datapath. It consumes the 16x-oversample `rx_tick` strobe from `baud_gen` and de-serialises an asynchronous `i_rx` line into parallel words. Each frame is start, DATA_BITS data bits (LSB first), an optional parity bit, and one stop bit. Each frame is reported with a one-cycle valid pulse plus framing and parity error flags. It sits between the pad-side RX line and the receive FIFO / register interface.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5..8.
- `PARITY_EN`, 0: 1 = a parity bit follows the data bits.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even parity. Ignored when PARITY_EN=0.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_tick` in 1: one-`clk` pulse at 16x the baud rate, from `baud_gen`.
- `i_rx` in 1: asynchronous serial input; idles high.
- `o_data` out DATA_BITS: last received word. Reset value 0.
- `o_valid` out 1: one-cycle pulse at frame end. Reset value 0.
- `o_frame_err` out 1: stop bit sampled 0. Valid with `o_valid`, held until the next `o_valid`. Reset value 0.
- `o_parity_err` out 1: parity mismatch. Valid with `o_valid`, held until the next `o_valid`. Always 0 when PARITY_EN=0. Reset value 0.
- `o_busy` out 1: high whenever the FSM is not in IDLE. Reset value 0.

## Operation
- **Input synchroniser:** `i_rx` passes through a 2-flop synchroniser to give `rx_s`. Both flops reset to 1. All FSM decisions use `rx_s` only.
- **Registers:**
  - 4-bit tick counter `tcnt`.
  - 3-bit bit counter `bcnt`.
  - DATA_BITS shift register.
  - Running parity (XOR of data bits).
- **Advance rule:** FSM and counters advance only in cycles where `rx_tick`=1. In other cycles everything holds.
- **IDLE:** on `rx_tick` with `rx_s`=0, go to START with `tcnt`=0.
- **START:**
  - On `rx_tick`: `tcnt`++.
  - At the tick where `tcnt`==7 (mid start bit): if `rx_s`=0, go to DATA with `tcnt`=0, `bcnt`=0. Otherwise it is a false start: go to IDLE with no outputs changed.
- **DATA:**
  - On `rx_tick`: `tcnt`++.
  - At `tcnt`==15: sample `rx_s` into the shift register MSB and shift right, so the first bit received lands in bit 0. Also XOR the sample into parity and set `tcnt`=0.
  - If `bcnt`==DATA_BITS-1: go to PARITY when PARITY_EN=1, else STOP. Otherwise `bcnt`++.
- **PARITY:**
  - At `tcnt`==15: parity error = (sampled bit != data parity XOR PARITY_ODD).
  - Go to STOP.
- **STOP:**
  - At `tcnt`==15: sample the stop bit.
  - In the next cycle, register the outputs: `o_data` = shift register, `o_frame_err` = ~stop, `o_parity_err` = computed value, and pulse `o_valid`.
  - FSM returns to IDLE in the same cycle as the `o_valid` pulse. This allows the next start edge to be detected during the second half of the stop bit.
- **Error frames:** `o_valid` pulses on every completed frame, including erroneous ones. A break (all zeros plus stop=0) reports data 0 with `o_frame_err`=1.
- **Reset:** reset asserted at any time, including mid-frame, returns to IDLE next cycle. It clears all outputs and counters and sets the synchroniser to 1. A partial frame is discarded without any `o_valid`.

## Timing
- **Sample points:** each data, parity and stop bit is sampled 16 ticks after the previous sample point, i.e. at bit centre. The start bit is sampled 8 ticks after its detection.
- **Latency:** `o_valid` rises 1 clk after the `rx_tick` that samples the stop bit. Measured from the `i_rx` edges, the synchroniser adds a further 2 clk.
- **Total frame length:**
  - From start detection to `o_valid`: 8 + 16·(DATA_BITS + PARITY_EN + 1) ticks + 1 clk.
  - For 8N1 this is 152 ticks + 1 clk.
- **Tick filtering:** `rx_tick` pulses wider than 1 clk are not supported. Each high cycle counts as one tick.
- **Divisor changes:** a `baud_gen` divisor change mid-frame is not compensated. The frame completes at the new tick rate.

## Test plan
- **8N1 nominal:** 50 MHz, `baud_gen` divisor 27; drive 0xA5 at a 432-clk bit period. Required: `o_data`=0xA5, a single `o_valid` pulse, both error flags 0, `o_busy` low after the pulse.
- **Glitch reject:** drive `i_rx` low for 4 ticks (108 clk), then high. Required: no `o_valid`, `o_busy` returns low by tick 8, `o_data` unchanged.
- **Framing error:** send 0x3C with stop bit = 0. Required: `o_valid` pulse, `o_data`=0x3C, `o_frame_err`=1, `o_parity_err`=0. The next good frame 0x55 clears `o_frame_err`.
- **Parity (PARITY_EN=1, PARITY_ODD=0):**
  - 0x37 with parity bit 1 gives `o_parity_err`=0.
  - The same word with parity bit 0 gives `o_parity_err`=1 and `o_data`=0x37.
- **Back-to-back frames:** send 0x00, 0xFF, 0x81 with no idle gap between stop and start. Required: three `o_valid` pulses in order, with no lost frames and no error flags.
- **Reset mid-frame:** assert `rst` for 1 clk after the 4th data bit. Required: all outputs 0 next cycle and no `o_valid` for the aborted frame. A following 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with parity and framing checks
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s, mid, par, par_n, perr, perr_n, fin;
  logic [3:0] tcnt, tcnt_n;
  logic [2:0] bcnt, bcnt_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  assign rx_s = sync[1];
  assign mid = tcnt == 4'd15;
  assign o_busy = state != IDLE;
  always_comb begin
    state_n = state;
    tcnt_n = tcnt;
    bcnt_n = bcnt;
    sh_n = sh;
    par_n = par;
    perr_n = perr;
    fin = 1'b0;
    if (rx_tick) begin
      tcnt_n = tcnt + 4'd1;
      case (state)
        IDLE: begin
          tcnt_n = '0;
          par_n = 1'b0;
          perr_n = 1'b0;
          state_n = rx_s ? IDLE : START;
        end
        START: if (tcnt == 4'd7) begin
          tcnt_n = '0;
          bcnt_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end
        DATA: if (mid) begin
          sh_n = {rx_s, sh[DATA_BITS-1:1]};
          par_n = par ^ rx_s;
          bcnt_n = bcnt + 3'd1;
          if (bcnt == 3'(DATA_BITS - 1)) state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: if (mid) begin
          perr_n = rx_s != (par ^ (PARITY_ODD != 0));
          state_n = STOP;
        end
        STOP: if (mid) begin
          fin = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sync <= 2'b11;
      tcnt <= '0;
      bcnt <= '0;
      sh <= '0;
      par <= 1'b0;
      perr <= 1'b0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_frame_err <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      sync <= {sync[0], i_rx};
      state <= state_n;
      tcnt <= tcnt_n;
      bcnt <= bcnt_n;
      sh <= sh_n;
      par <= par_n;
      perr <= perr_n;
      o_valid <= fin;
      if (fin) begin
        o_data <= sh;
        o_frame_err <= ~rx_s;
        o_parity_err <= perr;
      end
    end
  end
endmodule
